// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock parametrised FIFO.
// Holds the read-mode enum, width derivations and parameter legality predicates.
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence the extra state.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  function automatic bit afull_ok(input int depth, input int thresh);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

  function automatic bit aempty_ok(input int depth, input int thresh);
    return (thresh >= 0) && (thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO (slave).
// Carries write data/request, read request, read data and all status flags.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, rd_en,
    input  full, almost_full, dout, valid, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, almost_full, dout, valid, empty, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
// Intended to map onto distributed RAM; contents are deliberately never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 18,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int         AW   = clog2(DEPTH);
  localparam int         CW   = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH=%0d must be a power of 2 and >= 4", DEPTH);
  end
  if (!afull_ok(DEPTH, AFULL_THRESH)) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THRESH=%0d out of range 1..DEPTH", AFULL_THRESH);
  end
  if (!aempty_ok(DEPTH, AEMPTY_THRESH)) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THRESH=%0d out of range 0..DEPTH-1", AEMPTY_THRESH);
  end

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // In FWFT mode valid is exactly ~empty, so one accept term serves both modes.
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = bus.wr_en & full;
    udf_d   = bus.rd_en & ~rd_acc;
    if (wr_acc) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  if (MODE == MODE_STD) begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    // Output register gives one-cycle latency; dout holds between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= ram_rdata;
        end
      end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
  end else begin : g_fwft
    assign bus.dout  = empty ? '0 : ram_rdata;
    assign bus.valid = ~empty;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance
// driven side by side, with hand-computed expectations checked on the falling edge.
module tb_sync_fifo_param;

  localparam int WIDTH = 18;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_std ();
  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_fwft ();

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(14),
                    .AEMPTY_THRESH(2), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(if_std));

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(14),
                    .AEMPTY_THRESH(2), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(if_fwft));

  task automatic idle();
    if_std.wr_en  = 1'b0;
    if_std.rd_en  = 1'b0;
    if_fwft.wr_en = 1'b0;
    if_fwft.rd_en = 1'b0;
  endtask

  task automatic drive_both(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    if_std.wr_en  = wr;
    if_std.rd_en  = rd;
    if_std.din    = d;
    if_fwft.wr_en = wr;
    if_fwft.rd_en = rd;
    if_fwft.din   = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if_std.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", if_std.count); end
    total++; if (if_std.empty !== 1'b1 || if_std.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b/%b exp=1/1", if_std.empty, if_std.almost_empty); end
    total++; if (if_std.full !== 1'b0 || if_std.almost_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b/%b exp=0/0", if_std.full, if_std.almost_full); end
    total++; if (if_std.valid !== 1'b0 || if_std.dout !== 18'd0) begin bad++; $display("FAIL reset_out got valid=%b dout=%0h exp 0/0", if_std.valid, if_std.dout); end
    total++; if (if_std.overflow !== 1'b0 || if_std.underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0/0", if_std.overflow, if_std.underflow); end
    total++; if (if_fwft.valid !== 1'b0 || if_fwft.dout !== 18'd0 || if_fwft.empty !== 1'b1) begin bad++; $display("FAIL reset_fwft got valid=%b dout=%0h empty=%b", if_fwft.valid, if_fwft.dout, if_fwft.empty); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      if_std.din   = 18'(i);
      if_std.wr_en = 1'b1;
      @(negedge clk);
      total++; if (if_std.count !== 5'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, if_std.count, i); end
      total++; if (if_std.almost_full !== (i >= 14)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, if_std.almost_full, (i >= 14)); end
      total++; if (if_std.full !== (i == 16)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, if_std.full, (i == 16)); end
      total++; if (if_std.overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf[%0d] got=%b exp=0", i, if_std.overflow); end
      $display("fill write %0d count=%0d", i, if_std.count);
    end
    if_std.din = 18'd17;
    @(negedge clk);
    if_std.wr_en = 1'b0;
    total++; if (if_std.overflow !== 1'b1) begin bad++; $display("FAIL overflow_pulse got=%b exp=1", if_std.overflow); end
    total++; if (if_std.count !== 5'd16) begin bad++; $display("FAIL overflow_count got=%0d exp=16", if_std.count); end
    @(negedge clk);
    total++; if (if_std.overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", if_std.overflow); end
    $display("test_fill done");
  endtask

  task automatic test_drain_std();
    if_std.rd_en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        total++; if (if_std.valid !== 1'b1 || if_std.dout !== 18'(k)) begin bad++; $display("FAIL drain_data[%0d] got valid=%b dout=%0d exp 1/%0d", k, if_std.valid, if_std.dout, k); end
        total++; if (if_std.count !== 5'(16 - k)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, if_std.count, 16 - k); end
        total++; if (if_std.empty !== (k == 16) || if_std.almost_empty !== (k >= 14)) begin bad++; $display("FAIL drain_flags[%0d] got e=%b ae=%b", k, if_std.empty, if_std.almost_empty); end
        total++; if (if_std.underflow !== 1'b0) begin bad++; $display("FAIL drain_udf[%0d] got=%b exp=0", k, if_std.underflow); end
      end else begin
        total++; if (if_std.underflow !== 1'b1 || if_std.valid !== 1'b0) begin bad++; $display("FAIL underflow_pulse got udf=%b valid=%b exp 1/0", if_std.underflow, if_std.valid); end
      end
      $display("drain read %0d dout=%0d valid=%b", k, if_std.dout, if_std.valid);
    end
    if_std.rd_en = 1'b0;
    @(negedge clk);
    total++; if (if_std.underflow !== 1'b0 || if_std.dout !== 18'd16) begin bad++; $display("FAIL drain_hold got udf=%b dout=%0d exp 0/16", if_std.underflow, if_std.dout); end
    $display("test_drain_std done");
  endtask

  task automatic test_fwft_single();
    if_fwft.din   = 18'h2A;
    if_fwft.wr_en = 1'b1;
    @(negedge clk);
    if_fwft.wr_en = 1'b0;
    total++; if (if_fwft.valid !== 1'b1 || if_fwft.dout !== 18'h2A) begin bad++; $display("FAIL fwft_show got valid=%b dout=%0h exp 1/2a", if_fwft.valid, if_fwft.dout); end
    @(negedge clk);
    total++; if (if_fwft.valid !== 1'b1 || if_fwft.dout !== 18'h2A || if_fwft.count !== 5'd1) begin bad++; $display("FAIL fwft_hold got valid=%b dout=%0h count=%0d", if_fwft.valid, if_fwft.dout, if_fwft.count); end
    if_fwft.rd_en = 1'b1;
    @(negedge clk);
    if_fwft.rd_en = 1'b0;
    total++; if (if_fwft.valid !== 1'b0 || if_fwft.dout !== 18'd0 || if_fwft.empty !== 1'b1) begin bad++; $display("FAIL fwft_pop got valid=%b dout=%0h empty=%b exp 0/0/1", if_fwft.valid, if_fwft.dout, if_fwft.empty); end
    total++; if (if_fwft.underflow !== 1'b0) begin bad++; $display("FAIL fwft_pop_udf got=%b exp=0", if_fwft.underflow); end
    $display("test_fwft_single done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive_both(1'b1, 1'b0, 18'(i));
      @(negedge clk);
    end
    for (int k = 0; k < 40; k++) begin
      total++; if (if_fwft.dout !== 18'(k + 1) || if_fwft.valid !== 1'b1) begin bad++; $display("FAIL b2b_fwft[%0d] got dout=%0d valid=%b exp %0d/1", k, if_fwft.dout, if_fwft.valid, k + 1); end
      drive_both(1'b1, 1'b1, 18'(k + 9));
      @(negedge clk);
      total++; if (if_std.dout !== 18'(k + 1) || if_std.valid !== 1'b1) begin bad++; $display("FAIL b2b_std[%0d] got dout=%0d valid=%b exp %0d/1", k, if_std.dout, if_std.valid, k + 1); end
      total++; if (if_std.count !== 5'd8 || if_fwft.count !== 5'd8) begin bad++; $display("FAIL b2b_count[%0d] got=%0d/%0d exp=8", k, if_std.count, if_fwft.count); end
      total++; if ((if_std.overflow | if_std.underflow | if_fwft.overflow | if_fwft.underflow) !== 1'b0) begin bad++; $display("FAIL b2b_err[%0d] got an error pulse", k); end
      $display("b2b cycle %0d std=%0d fwft=%0d", k, if_std.dout, if_fwft.dout);
    end
    idle();
    @(negedge clk);
    total++; if (if_fwft.dout !== 18'd41) begin bad++; $display("FAIL b2b_tail got=%0d exp=41", if_fwft.dout); end
    $display("test_back_to_back done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive_both(1'b1, 1'b0, 18'(100 + i));
      @(negedge clk);
    end
    drive_both(1'b1, 1'b1, 18'd999);
    @(negedge clk);
    idle();
    total++; if (if_std.overflow !== 1'b1 || if_fwft.overflow !== 1'b1) begin bad++; $display("FAIL full_rw_ovf got=%b/%b exp=1/1", if_std.overflow, if_fwft.overflow); end
    total++; if (if_std.count !== 5'd15 || if_fwft.count !== 5'd15) begin bad++; $display("FAIL full_rw_count got=%0d/%0d exp=15", if_std.count, if_fwft.count); end
    total++; if (if_std.valid !== 1'b1 || if_std.dout !== 18'd101) begin bad++; $display("FAIL full_rw_std got valid=%b dout=%0d exp 1/101", if_std.valid, if_std.dout); end
    total++; if (if_fwft.dout !== 18'd102) begin bad++; $display("FAIL full_rw_fwft got=%0d exp=102", if_fwft.dout); end
    $display("full simultaneous rw done");
    do_reset();
    drive_both(1'b1, 1'b1, 18'h55);
    @(negedge clk);
    idle();
    total++; if (if_std.underflow !== 1'b1 || if_fwft.underflow !== 1'b1) begin bad++; $display("FAIL empty_rw_udf got=%b/%b exp=1/1", if_std.underflow, if_fwft.underflow); end
    total++; if (if_std.count !== 5'd1 || if_fwft.count !== 5'd1) begin bad++; $display("FAIL empty_rw_count got=%0d/%0d exp=1", if_std.count, if_fwft.count); end
    total++; if (if_std.valid !== 1'b0 || if_std.overflow !== 1'b0) begin bad++; $display("FAIL empty_rw_std got valid=%b ovf=%b exp 0/0", if_std.valid, if_std.overflow); end
    total++; if (if_fwft.valid !== 1'b1 || if_fwft.dout !== 18'h55) begin bad++; $display("FAIL empty_rw_fwft got valid=%b dout=%0h exp 1/55", if_fwft.valid, if_fwft.dout); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      drive_both(1'b1, 1'b0, 18'(i));
      @(negedge clk);
    end
    drive_both(1'b0, 1'b1, 18'd0);
    @(negedge clk);
    @(negedge clk);
    total++; if (if_std.count !== 5'd9 || if_std.valid !== 1'b1 || if_std.dout !== 18'd2) begin bad++; $display("FAIL pre_rst_std got count=%0d valid=%b dout=%0d", if_std.count, if_std.valid, if_std.dout); end
    total++; if (if_fwft.dout !== 18'd3) begin bad++; $display("FAIL pre_rst_fwft got=%0d exp=3", if_fwft.dout); end
    idle();
    rst = 1'b1;
    #1;
    total++; if (if_std.count !== 5'd0 || if_fwft.count !== 5'd0) begin bad++; $display("FAIL async_rst_count got=%0d/%0d exp=0", if_std.count, if_fwft.count); end
    total++; if (if_std.empty !== 1'b1 || if_fwft.empty !== 1'b1) begin bad++; $display("FAIL async_rst_empty got=%b/%b exp=1", if_std.empty, if_fwft.empty); end
    total++; if (if_std.valid !== 1'b0 || if_std.dout !== 18'd0) begin bad++; $display("FAIL async_rst_std got valid=%b dout=%0d exp 0/0", if_std.valid, if_std.dout); end
    total++; if (if_fwft.valid !== 1'b0 || if_fwft.dout !== 18'd0) begin bad++; $display("FAIL async_rst_fwft got valid=%b dout=%0d exp 0/0", if_fwft.valid, if_fwft.dout); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_both(1'b1, 1'b0, 18'h3FFFF);
    @(negedge clk);
    drive_both(1'b0, 1'b0, 18'd0);
    total++; if (if_fwft.valid !== 1'b1 || if_fwft.dout !== 18'h3FFFF) begin bad++; $display("FAIL post_rst_fwft got valid=%b dout=%0h exp 1/3ffff", if_fwft.valid, if_fwft.dout); end
    if_std.rd_en = 1'b1;
    @(negedge clk);
    if_std.rd_en = 1'b0;
    total++; if (if_std.valid !== 1'b1 || if_std.dout !== 18'h3FFFF) begin bad++; $display("FAIL post_rst_std got valid=%b dout=%0h exp 1/3ffff", if_std.valid, if_std.dout); end
    $display("test_reset_midstream done");
  endtask

  initial begin
    if_std.din  = '0;
    if_fwft.din = '0;
    idle();
    test_reset();
    test_fill();
    test_drain_std();
    test_fwft_single();
    test_back_to_back();
    test_simultaneous();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
